// File: rtl/imem_access_arbiter.sv
// Shares the single-ported instruction memory between interrupt-vector reads, loader writes and fetch reads.
// Optional IMEM_WRITE_PROTECT_EN rejects loader writes that target the interrupt area.
module imem_access_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned IRQ_AREA       = 32,
    parameter int unsigned MAX_LOAD_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [15:0]       f_rdata,
    output logic              f_rvalid,
    input  logic              i_req,
    input  logic [4:0]        i_idx,
    output logic              i_ack,
    output logic [15:0]       i_rdata,
    output logic              i_rvalid,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [15:0]       l_wdata,
    output logic              l_ack,
    output logic              l_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_cs,
    input  logic [15:0]       mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_LOAD_BURST + 1);
`ifdef IMEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_L, GNT_F} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_full;
    logic             reader_wait;
    logic             prot_hit;
    logic             err_q;

    assign burst_full  = (burst_cnt == CNT_W'(MAX_LOAD_BURST));
    assign reader_wait = f_req | i_req;
    assign prot_hit    = PROT_EN && (l_addr[19:0] < 20'(IRQ_AREA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration happens every edge since each grant lasts a single cycle.
    always_comb begin
        state_nxt = IDLE;
        if (i_req) begin
            state_nxt = GNT_I;
        end else if (l_req && !(f_req && burst_full)) begin
            state_nxt = GNT_L;
        end else if (f_req) begin
            state_nxt = GNT_F;
        end
    end

    always_comb begin
        f_ack = 1'b0;
        i_ack = 1'b0;
        l_ack = 1'b0;
        l_err = 1'b0;
        busy  = (state != IDLE);
        case (state)
            GNT_I: i_ack = 1'b1;
            GNT_F: f_ack = 1'b1;
            GNT_L: begin
                l_ack = 1'b1;
                l_err = err_q;
            end
            default: ;
        endcase
    end

    // Memory strobes are registered from the upcoming grant so they line up with the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_cs    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_nxt == GNT_L && reader_wait) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= '0;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_cs    <= 1'b0;
            err_q     <= 1'b0;
            case (state_nxt)
                GNT_I: begin
                    mem_addr <= ADDR_W'(i_idx);
                    mem_read <= 1'b1;
                    mem_cs   <= 1'b1;
                end
                GNT_F: begin
                    mem_addr <= f_addr;
                    mem_read <= 1'b1;
                    mem_cs   <= 1'b1;
                end
                GNT_L: begin
                    if (prot_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        mem_addr  <= l_addr;
                        mem_wdata <= l_wdata;
                        mem_write <= 1'b1;
                        mem_cs    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rdata  <= '0;
            i_rdata  <= '0;
            f_rvalid <= 1'b0;
            i_rvalid <= 1'b0;
        end else begin
            f_rvalid <= (state == GNT_F);
            i_rvalid <= (state == GNT_I);
            if (state == GNT_F) begin
                f_rdata <= mem_rdata;
            end
            if (state == GNT_I) begin
                i_rdata <= mem_rdata;
            end
        end
    end

endmodule
